fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  decode cannot accept; holds the output instruction.
REQ-005 branch_taken  input  1  one-cycle redirect request.
REQ-006 branch_target  input  32  redirect address; bits [1:0] are ignored and forced to 00.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  word-aligned read address (equals PC).
REQ-009 imem_rdata  input  32  read data, valid only in the cycle imem_ack=1.
REQ-010 imem_ack  input  1  read complete, one-cycle pulse, arrives at least 1 cycle after imem_req rises.
REQ-011 instr  output  32  IF/ID instruction register.
REQ-012 opcode  output  6  instr[31:26]; feeds the control decoder OpCode input.
REQ-013 pc_plus4  output  32  address of instr plus 4.
REQ-014 instr_valid  output  1  instr/pc_plus4 hold a live instruction.

Function
REQ-015 The states SHALL be S_REQ (request outstanding), S_FULL (skid buffer occupied, no request) and S_DROP (outstanding request to be discarded).
REQ-016 In S_REQ and S_DROP, imem_req SHALL be 1; in S_FULL it SHALL be 0.
REQ-017 Once raised, imem_req and imem_addr SHALL stay stable up to and including the ack cycle.
REQ-018 The output register is free when instr_valid=0 or stall=0.
REQ-019 In S_REQ with ack and a free output, the block SHALL load instr<=imem_rdata, pc_plus4<=PC+4, instr_valid<=1 and PC<=PC+4, then stay in S_REQ; a new request is issued the next cycle (throughput 1 instruction per ack).
REQ-020 In S_REQ with ack and a non-free output, the block SHALL load the skid buffer with rdata and PC+4, set PC<=PC+4 and move to S_FULL.
REQ-021 In S_FULL with stall=0, the block SHALL move the skid contents into instr/pc_plus4, set instr_valid=1 and return to S_REQ.
REQ-022 With instr_valid=1, stall=0 and no new load, instr_valid SHALL clear (instruction consumed); instr and pc_plus4 hold their values.
REQ-023 With stall=1, instr, pc_plus4 and instr_valid SHALL hold.
REQ-024 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-025 branch_taken SHALL take priority over stall and over any load. It SHALL set instr_valid<=0 and empty the skid, with these transitions:
 - S_REQ without ack: save the target, go to S_DROP.
 - S_REQ with ack: discard rdata, PC<=target, stay in S_REQ.
 - S_FULL: PC<=target, go to S_REQ.
 - S_DROP: overwrite the saved target.
REQ-026 In S_DROP on ack, rdata SHALL be discarded, PC<=saved target and the state SHALL move to S_REQ; with no ack the state stays S_DROP.
REQ-027 A branch in the same cycle as an S_DROP ack SHALL use the new branch_target.

Reset
REQ-028 rst=1 SHALL immediately force: PC=RESET_PC, state=S_REQ, imem_req=0, instr=0 (opcode 000000), pc_plus4=0, instr_valid=0, skid empty.
REQ-029 The first imem_req=1 SHALL appear on the first rising edge after rst falls.
REQ-030 A reset mid-request SHALL abandon the request with no data captured.

Verification
REQ-031 Reset RESET_PC=0x100, ack 2 cycles after each req, stall=0 -> imem_addr 0x100, 0x104, 0x108; instr_valid pulses; pc_plus4 0x104, 0x108, 0x10C.
REQ-032 Hold stall=1 with instr_valid=1, then ack data 0x8C220004 -> state S_FULL, imem_req=0; release stall -> instr=0x8C220004, opcode=100011.
REQ-033 branch_taken with target 0x203 while a request to 0x40 is outstanding -> req held until ack, data dropped, next imem_addr=0x200, instr_valid stays 0.
REQ-034 branch_taken in an ack cycle with stall=1 and S_FULL pending -> skid and instr_valid cleared, next imem_addr=target.
REQ-035 PC=0xFFFFFFFC with ack -> next imem_addr=0x00000000.
REQ-036 Assert rst mid-request -> imem_req=0 and instr_valid=0 before the next edge; PC=RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-unit bus: instruction-memory handshake plus the IF/ID register
// and the decode-side stall/redirect controls.
interface fetch_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc_plus4;
   logic        instr_valid;

   modport master (
      input  stall, branch_taken, branch_target, imem_rdata, imem_ack,
      output imem_req, imem_addr, instr, opcode, pc_plus4, instr_valid
   );

   modport slave (
      output stall, branch_taken, branch_target, imem_rdata, imem_ack,
      input  imem_req, imem_addr, instr, opcode, pc_plus4, instr_valid
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, a one-entry skid buffer
// behind the IF/ID register, and branch redirect that drops in-flight reads.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic    clk,
   input logic    rst,
   fetch_if.master bus
);

   typedef enum logic [1:0] {S_REQ, S_FULL, S_DROP} state_t;

   state_t      state, state_n;
   logic        started;
   logic [31:0] pc, pc_n;
   logic [31:0] instr_q, instr_n;
   logic [31:0] pc4_q, pc4_n;
   logic        vld_q, vld_n;
   logic [31:0] skid_instr, skid_instr_n;
   logic [31:0] skid_pc4, skid_pc4_n;
   logic [31:0] tgt, tgt_n;
   logic [31:0] br_tgt;
   logic [31:0] pc_inc;
   logic        free;
   logic        req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_REQ;
         started    <= 1'b0;
         pc         <= RESET_PC;
         instr_q    <= '0;
         pc4_q      <= '0;
         vld_q      <= 1'b0;
         skid_instr <= '0;
         skid_pc4   <= '0;
         tgt        <= '0;
      end else begin
         state      <= state_n;
         started    <= 1'b1;
         pc         <= pc_n;
         instr_q    <= instr_n;
         pc4_q      <= pc4_n;
         vld_q      <= vld_n;
         skid_instr <= skid_instr_n;
         skid_pc4   <= skid_pc4_n;
         tgt        <= tgt_n;
      end
   end

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      instr_n      = instr_q;
      pc4_n        = pc4_q;
      vld_n        = vld_q;
      skid_instr_n = skid_instr;
      skid_pc4_n   = skid_pc4;
      tgt_n        = tgt;
      br_tgt       = bus.branch_target & ~32'd3;
      pc_inc       = pc + 32'd4;
      free         = !vld_q || !bus.stall;
      // The cycle right after reset issues no request; the first one starts on the next edge.
      req          = started && (state != S_FULL);

      if (!started) begin
         if (bus.branch_taken) begin
            pc_n = br_tgt;
         end
      end else if (bus.branch_taken) begin
         vld_n = 1'b0;
         unique case (state)
            S_REQ: begin
               if (bus.imem_ack) begin
                  pc_n = br_tgt;
               end else begin
                  tgt_n   = br_tgt;
                  state_n = S_DROP;
               end
            end
            S_FULL: begin
               pc_n    = br_tgt;
               state_n = S_REQ;
            end
            S_DROP: begin
               // A branch coinciding with the dropped ack wins over the saved target.
               if (bus.imem_ack) begin
                  pc_n    = br_tgt;
                  state_n = S_REQ;
               end else begin
                  tgt_n = br_tgt;
               end
            end
            default: state_n = S_REQ;
         endcase
      end else begin
         if (vld_q && !bus.stall) begin
            vld_n = 1'b0;
         end
         unique case (state)
            S_REQ: begin
               if (bus.imem_ack) begin
                  pc_n = pc_inc;
                  if (free) begin
                     instr_n = bus.imem_rdata;
                     pc4_n   = pc_inc;
                     vld_n   = 1'b1;
                  end else begin
                     skid_instr_n = bus.imem_rdata;
                     skid_pc4_n   = pc_inc;
                     state_n      = S_FULL;
                  end
               end
            end
            S_FULL: begin
               if (!bus.stall) begin
                  instr_n = skid_instr;
                  pc4_n   = skid_pc4;
                  vld_n   = 1'b1;
                  state_n = S_REQ;
               end
            end
            S_DROP: begin
               if (bus.imem_ack) begin
                  pc_n    = tgt;
                  state_n = S_REQ;
               end
            end
            default: state_n = S_REQ;
         endcase
      end
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc;
   assign bus.instr       = instr_q;
   assign bus.opcode      = instr_q[31:26];
   assign bus.pc_plus4    = pc4_q;
   assign bus.instr_valid = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run checked
// against an instruction-stream reference model.
module tb_fetch_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fetch_if bus();

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   // memory responder controls (written by tests) and state (written by responder)
   int          mem_lat = 2;
   bit          mem_rand = 0;
   int          rand_lat = 1;
   int          mem_cnt = 0;
   bit          mem_prev = 0;
   logic [31:0] mem_rec = '0;
   bit          stab_err = 0;
   logic [31:0] ack_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0104) return 32'h8C22_0004;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   // Responds to each request after a configurable number of cycles, and
   // flags any address change while a request is outstanding.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = '0;
         mem_cnt        = 0;
         ack_q.delete();
      end else begin
         mem_prev       = bus.imem_ack;
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = $urandom;
         if (!bus.imem_req) begin
            mem_cnt = 0;
         end else if (mem_prev || mem_cnt == 0) begin
            mem_cnt = 1;
            mem_rec = bus.imem_addr;
         end else begin
            if (bus.imem_addr !== mem_rec) stab_err = 1;
            mem_cnt++;
         end
         if (bus.imem_req && mem_cnt > (mem_rand ? rand_lat : mem_lat)) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
            ack_q.push_back(bus.imem_addr);
            rand_lat = $urandom_range(1, 3);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // sel 0: instr_valid, 1: imem_ack, 2: imem_addr==v, 3: imem_addr!=v
   task automatic wait_for(input int sel, input logic [31:0] v, output bit ok);
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((sel == 0 && bus.instr_valid === 1'b1) ||
             (sel == 1 && bus.imem_ack === 1'b1) ||
             (sel == 2 && bus.imem_addr === v) ||
             (sel == 3 && bus.imem_addr !== v)) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", bus.imem_req); end
      checks++;
      if (bus.imem_addr !== RPC) begin failures++; $display("FAIL reset_addr got=%0h exp=%0h", bus.imem_addr, RPC); end
      checks++;
      if (bus.instr !== 32'h0 || bus.opcode !== 6'h0) begin failures++; $display("FAIL reset_instr got=%0h/%0h exp=0/0", bus.instr, bus.opcode); end
      checks++;
      if (bus.pc_plus4 !== 32'h0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_pc4_vld got=%0h/%0h exp=0/0", bus.pc_plus4, bus.instr_valid); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req_before_edge got=%0h exp=0", bus.imem_req); end
      @(posedge clk);
      #2;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin failures++; $display("FAIL first_req got=%0h@%0h exp=1@%0h", bus.imem_req, bus.imem_addr, RPC); end
   endtask

   task automatic test_sequential();
      bit ok;
      logic [31:0] a;
      mem_lat = 2;
      mem_rand = 0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         a = RPC + 32'(4 * k);
         wait_for(0, '0, ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL seq_timeout k=%0d got=no_valid exp=valid", k); end
         else if (bus.instr !== mem_word(a) || bus.pc_plus4 !== a + 32'd4) begin
            failures++; $display("FAIL seq_data k=%0d got=%0h/%0h exp=%0h/%0h", k, bus.instr, bus.pc_plus4, mem_word(a), a + 32'd4);
         end
         @(negedge clk);
         checks++;
         if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL seq_pulse k=%0d got=%0h exp=0", k, bus.instr_valid); end
      end
      checks++;
      if (ack_q.size() < 3) begin failures++; $display("FAIL seq_acks got=%0d exp>=3", ack_q.size()); end
      else if (ack_q[0] !== RPC || ack_q[1] !== RPC + 32'd4 || ack_q[2] !== RPC + 32'd8) begin
         failures++; $display("FAIL seq_addrs got=%0h,%0h,%0h exp=%0h,%0h,%0h", ack_q[0], ack_q[1], ack_q[2], RPC, RPC + 32'd4, RPC + 32'd8);
      end
   endtask

   task automatic test_stall_skid();
      bit ok;
      mem_lat = 2;
      do_reset();
      wait_for(0, '0, ok);
      bus.stall = 1'b1;
      wait_for(1, '0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL skid_ack_timeout got=no_ack exp=ack"); end
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr !== mem_word(RPC)) begin
         failures++; $display("FAIL skid_full got=req%0h vld%0h %0h exp=req0 vld1 %0h", bus.imem_req, bus.instr_valid, bus.instr, mem_word(RPC));
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL skid_req_low got=%0h exp=0", bus.imem_req); end
      bus.stall = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.instr !== 32'h8C22_0004 || bus.opcode !== 6'b100011 || bus.instr_valid !== 1'b1) begin
         failures++; $display("FAIL skid_release got=%0h op=%0h vld=%0h exp=8c220004 op=23 vld=1", bus.instr, bus.opcode, bus.instr_valid);
      end
      checks++;
      if (bus.pc_plus4 !== 32'h108 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108) begin
         failures++; $display("FAIL skid_next got=pc4 %0h req%0h@%0h exp=pc4 108 req1@108", bus.pc_plus4, bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_branch_drop();
      bit ok;
      bit held_bad;
      int n;
      mem_lat = 4;
      do_reset();
      @(negedge clk);
      bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
      @(negedge clk);
      bus.branch_taken = 1'b0;
      wait_for(2, 32'h40, ok);
      checks++;
      if (!ok || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL drop_first ok=%0d got=vld%0h exp=vld0", ok, bus.instr_valid); end
      bus.branch_taken = 1'b1; bus.branch_target = 32'h203;
      @(negedge clk);
      bus.branch_taken = 1'b0;
      held_bad = 0;
      n = 0;
      while (bus.imem_addr === 32'h40 && n < 30) begin
         if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) held_bad = 1;
         @(negedge clk);
         n++;
      end
      checks++;
      if (held_bad || n != 4) begin failures++; $display("FAIL drop_hold got=bad%0d cycles=%0d exp=bad0 cycles=4", held_bad, n); end
      checks++;
      if (bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
         failures++; $display("FAIL drop_redirect got=req%0h@%0h vld%0h exp=req1@200 vld0", bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      wait_for(0, '0, ok);
      checks++;
      if (!ok || bus.instr !== mem_word(32'h200) || bus.pc_plus4 !== 32'h204) begin
         failures++; $display("FAIL drop_target_instr got=%0h/%0h exp=%0h/204", bus.instr, bus.pc_plus4, mem_word(32'h200));
      end
   endtask

   task automatic test_branch_ack_stall();
      bit ok;
      mem_lat = 2;
      do_reset();
      wait_for(0, '0, ok);
      bus.stall = 1'b1;
      wait_for(1, '0, ok);
      bus.branch_taken = 1'b1; bus.branch_target = 32'h301;
      @(negedge clk);
      bus.branch_taken = 1'b0;
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin
         failures++; $display("FAIL bra_ack got=vld%0h req%0h@%0h exp=vld0 req1@300", bus.instr_valid, bus.imem_req, bus.imem_addr);
      end
      wait_for(0, '0, ok);
      checks++;
      if (!ok || bus.instr !== mem_word(32'h300) || bus.pc_plus4 !== 32'h304) begin
         failures++; $display("FAIL bra_ack_target got=%0h/%0h exp=%0h/304", bus.instr, bus.pc_plus4, mem_word(32'h300));
      end
      bus.stall = 1'b0;
      wait_for(0, '0, ok);
      checks++;
      if (!ok || bus.instr !== mem_word(32'h304) || bus.pc_plus4 !== 32'h308) begin
         failures++; $display("FAIL bra_ack_next got=%0h/%0h exp=%0h/308", bus.instr, bus.pc_plus4, mem_word(32'h304));
      end
   endtask

   task automatic test_wrap();
      bit ok;
      mem_lat = 1;
      do_reset();
      @(negedge clk);
      bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFE;
      @(negedge clk);
      bus.branch_taken = 1'b0;
      wait_for(2, 32'hFFFF_FFFC, ok);
      wait_for(3, 32'hFFFF_FFFC, ok);
      checks++;
      if (!ok || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%0h exp=0", bus.imem_addr); end
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.pc_plus4 !== 32'h0 || bus.instr !== mem_word(32'hFFFF_FFFC)) begin
         failures++; $display("FAIL wrap_instr got=vld%0h %0h/%0h exp=vld1 %0h/0", bus.instr_valid, bus.instr, bus.pc_plus4, mem_word(32'hFFFF_FFFC));
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      mem_lat = 3;
      do_reset();
      wait_for(0, '0, ok);
      bus.stall = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=req%0h vld%0h exp=req0 vld0", bus.imem_req, bus.instr_valid); end
      checks++;
      if (bus.imem_addr !== RPC || bus.instr !== 32'h0) begin failures++; $display("FAIL rstmid_state got=%0h/%0h exp=%0h/0", bus.imem_addr, bus.instr, RPC); end
      @(negedge clk);
      rst = 1'b0;
      bus.stall = 1'b0;
      wait_for(0, '0, ok);
      checks++;
      if (!ok || bus.instr !== mem_word(RPC) || bus.pc_plus4 !== RPC + 32'd4) begin
         failures++; $display("FAIL rstmid_restart got=%0h/%0h exp=%0h/%0h", bus.instr, bus.pc_plus4, mem_word(RPC), RPC + 32'd4);
      end
   endtask

   // Reference: the delivered stream is mem_word(exp_pc), exp_pc, exp_pc+4, ...
   // restarting at the aligned target after every branch.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] hold_instr;
      logic [31:0] t;
      bit kill_pend, hold_pend, st, br;
      int consumed;
      mem_rand = 1;
      do_reset();
      exp_pc = RPC;
      kill_pend = 0;
      hold_pend = 0;
      hold_instr = '0;
      consumed = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (kill_pend) begin
            checks++;
            if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_kill c=%0d got=%0h exp=0", c, bus.instr_valid); end
         end else if (hold_pend) begin
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== hold_instr) begin
               failures++; $display("FAIL rnd_hold c=%0d got=vld%0h %0h exp=vld1 %0h", c, bus.instr_valid, bus.instr, hold_instr);
            end
         end
         if (bus.instr_valid === 1'b1) begin
            checks++;
            if (bus.instr !== mem_word(exp_pc) || bus.pc_plus4 !== exp_pc + 32'd4) begin
               failures++; $display("FAIL rnd_instr c=%0d got=%0h/%0h exp=%0h/%0h", c, bus.instr, bus.pc_plus4, mem_word(exp_pc), exp_pc + 32'd4);
            end
         end
         st = ($urandom_range(0, 2) == 0);
         br = ($urandom_range(0, 19) == 0);
         t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 16'hFFFF));
         kill_pend = br;
         hold_pend = !br && bus.instr_valid && st;
         hold_instr = bus.instr;
         if (br) begin
            exp_pc = {t[31:2], 2'b00};
         end else if (bus.instr_valid === 1'b1 && !st) begin
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         bus.stall = st;
         bus.branch_taken = br;
         bus.branch_target = t;
      end
      @(negedge clk);
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      mem_rand = 0;
      checks++;
      if (consumed < 150) begin failures++; $display("FAIL rnd_progress got=%0d exp>=150", consumed); end
      checks++;
      if (stab_err !== 1'b0) begin failures++; $display("FAIL req_stability got=%0d exp=0", stab_err); end
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = '0;
      test_reset();
      test_sequential();
      test_stall_skid();
      test_branch_drop();
      test_branch_ack_stall();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
